// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-Lite priority interconnect arbiters.
//   axil_rd_state_t : arbiter FSM states (IDLE / ADDR / DATA), also used by the write arbiter
//   idx_width()     : width of a binary index for n masters, never less than 1
package axil_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } axil_rd_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   req_i       : request vector
//   onehot_o    : one-hot of the lowest set request bit, zero when no request
//   idx_o       : binary index of that bit, zero when no request
//   any_valid_o : at least one request bit set
module axil_prio_enc
    import axil_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_valid_o
);

    logic found;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
                found       = 1'b1;
            end
        end
    end

    assign any_valid_o = |req_i;

endmodule

// File: rtl/axil_arbiter_rd.sv
// Fixed-priority read-channel arbiter (lowest master index wins, no fairness).
// A grant is held from arbitration through the AR handshake and the R
// handshake; on the R handshake the arbiter re-arbitrates in the same cycle.
//   aclk, aresetn    : clock, asynchronous active-low reset
//   m_axil_arvalid   : per-master AR requests
//   s_axil_arvalid/s_axil_arready : AR handshake at the slave
//   s_axil_rvalid/s_axil_rready   : R handshake at the slave
//   grant_rd         : registered one-hot grant, zero when idle
//   grant_idx        : registered binary index of grant_rd, zero when idle
//   busy             : a grant is held
module axil_arbiter_rd
    import axil_pkg::*;
#(
    parameter  int unsigned NUMBER_MASTER = 4,
    localparam int unsigned IDX_W         = idx_width(NUMBER_MASTER)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
    input  logic                     s_axil_arvalid,
    input  logic                     s_axil_arready,
    input  logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [NUMBER_MASTER-1:0] grant_rd,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy
);

    axil_rd_state_t           state_q, state_d;
    logic [NUMBER_MASTER-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic [NUMBER_MASTER-1:0] enc_onehot;
    logic [IDX_W-1:0]         enc_idx;
    logic                     enc_any;
    logic                     ar_hs;
    logic                     r_hs;

    axil_prio_enc #(
        .N (NUMBER_MASTER)
    ) u_prio_enc (
        .req_i       (m_axil_arvalid),
        .onehot_o    (enc_onehot),
        .idx_o       (enc_idx),
        .any_valid_o (enc_any)
    );

    assign ar_hs = s_axil_arvalid & s_axil_arready;
    assign r_hs  = s_axil_rvalid & s_axil_rready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        case (state_q)
            RD_IDLE: begin
                if (enc_any) begin
                    grant_d = enc_onehot;
                    idx_d   = enc_idx;
                    state_d = RD_ADDR;
                end
            end
            // R handshakes are ignored here; an AR handshake always wins.
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            // Back-to-back hand-over: the encoder output is taken directly,
            // so a new grant needs no idle bubble.
            RD_DATA: begin
                if (r_hs) begin
                    if (enc_any) begin
                        grant_d = enc_onehot;
                        idx_d   = enc_idx;
                        state_d = RD_ADDR;
                    end else begin
                        grant_d = '0;
                        idx_d   = '0;
                        state_d = RD_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                idx_d   = '0;
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= RD_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    assign grant_rd  = grant_q;
    assign grant_idx = idx_q;
    assign busy      = (state_q != RD_IDLE);

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// Self-checking bench for axil_arbiter_rd: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference
// model (current owner + whether its address phase is still open).
module tb_axil_arbiter_rd;

    logic       aclk;
    logic       aresetn;
    logic [3:0] m_axil_arvalid;
    logic       s_axil_arvalid;
    logic       s_axil_arready;
    logic       s_axil_rvalid;
    logic       s_axil_rready;
    logic [3:0] grant_rd;
    logic [1:0] grant_idx;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner = -1 when no master holds the channel.
    int owner     = -1;
    bit addr_open = 1'b0;

    axil_arbiter_rd #(
        .NUMBER_MASTER (4)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .m_axil_arvalid (m_axil_arvalid),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .grant_rd       (grant_rd),
        .grant_idx      (grant_idx),
        .busy           (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] req);
        for (int i = 0; i < 4; i++) begin
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // One clock of the reference model, applying the spec rules to the
    // inputs present at the rising edge.
    task automatic model_edge(input logic [3:0] req, input bit ar_hs, input bit r_hs);
        if (owner < 0) begin
            if (req != 4'd0) begin
                owner     = lowest(req);
                addr_open = 1'b1;
            end
        end else if (addr_open) begin
            if (ar_hs) addr_open = 1'b0;
        end else if (r_hs) begin
            if (req != 4'd0) begin
                owner     = lowest(req);
                addr_open = 1'b1;
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] eg;
        logic [31:0] ei;
        eg = (owner < 0) ? 32'd0 : (32'd1 << owner);
        ei = (owner < 0) ? 32'd0 : 32'(owner);
        chk({tag, ".grant"}, 32'(grant_rd), eg);
        chk({tag, ".idx"},   32'(grant_idx), ei);
        chk({tag, ".busy"},  32'(busy), (owner < 0) ? 32'd0 : 32'd1);
    endtask

    // Called at a falling edge: drive inputs, advance model across the next
    // rising edge, then check at the following falling edge.
    task automatic step(input string tag, input logic [3:0] req,
                        input logic arv, input logic ardy,
                        input logic rv, input logic rr);
        m_axil_arvalid = req;
        s_axil_arvalid = arv;
        s_axil_arready = ardy;
        s_axil_rvalid  = rv;
        s_axil_rready  = rr;
        if (aresetn) model_edge(req, arv & ardy, rv & rr);
        @(negedge aclk);
        check_outputs(tag);
    endtask

    initial begin
        aresetn        = 1'b0;
        m_axil_arvalid = '0;
        s_axil_arvalid = 1'b0;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        s_axil_rready  = 1'b0;
        @(negedge aclk);

        // Reset held with every master requesting.
        for (int i = 0; i < 3; i++) step("rst_hold", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b1;
        step("rst_rel", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_rel.grant0001", 32'(grant_rd), 32'h1);
        step("rst_ar", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        step("rst_r", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Single request with slow slave.
        step("single", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single.idx2", 32'(grant_idx), 32'd2);
        for (int i = 0; i < 3; i++) step("single_arwait", 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1);
        step("single_ar", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("single_rwait", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        step("single_r", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("release.idle", 32'(grant_rd), 32'h0);
        step("regrant", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Finish master 0, then contention between masters 1 and 3.
        step("c_ar0", 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
        step("c_r0", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("contend.grant0010", 32'(grant_rd), 32'h2);
        step("c_ar1", 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("c_r1", 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("contend.grant1000", 32'(grant_rd), 32'h8);
        chk("contend.busy", 32'(busy), 32'd1);

        // Late request from master 0 during master 3's DATA phase.
        step("late_ar3", 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("late_hold", 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("late.nopreempt", 32'(grant_rd), 32'h8);
        step("late_r3", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("late.grant0001", 32'(grant_rd), 32'h1);

        // Reset in the middle of a DATA phase.
        step("mid_ar", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst.grant_async", 32'(grant_rd), 32'h0);
        chk("midrst.busy_async", 32'(busy), 32'd0);
        owner     = -1;
        addr_open = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        step("midrst_idle", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        step("midrst_grant", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] req;
            req = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step("rand", req,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
